// File: rtl/mux_nto1_rr.sv
//============================================================================
// Module   : mux_nto1_rr
// Purpose  : Registered N:1 channel multiplexer with valid/ready handshake on
//            every input and on the output. Two selection modes:
//              mode=0 : fixed select through sel
//              mode=1 : round-robin arbitration over the valid channels
//            Optional build macro MUXNTO1_TAG_EN adds a registered source
//            channel index output (out_ch) alongside out_data.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mux_nto1_rr #(
    parameter int  WIDTH = 4,
    parameter int  NCH   = 4,
    localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
`ifdef MUXNTO1_TAG_EN
    output logic [SELW-1:0]      out_ch,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_load_en;
    logic             w_grant_valid;
    logic [SELW-1:0]  w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    // The output slot can take a new word when it is empty or being drained
    // this cycle, which keeps throughput at one word per clock.
    assign w_load_en = !r_out_valid || out_ready;

    // Grant selection: fixed index in mode 0, rotating priority in mode 1.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        if (!mode) begin
            // Comparing against every legal index means sel >= NCH never grants.
            for (int i = 0; i < NCH; i++) begin
                if ((int'(sel) == i) && in_valid[i]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = SELW'(i);
                end
            end
        end else begin
            // Walk the candidates from the farthest to the nearest so that the
            // first valid channel after the pointer is the one left standing.
            for (int k = NCH; k >= 1; k--) begin
                if (in_valid[(int'(r_rr_ptr) + k) % NCH]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = SELW'((int'(r_rr_ptr) + k) % NCH);
                end
            end
        end
    end

    // One-hot ready toward the granted producer; held off while in reset.
    always_comb begin
        in_ready = '0;
        if (!rst && w_load_en && w_grant_valid) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    // Ready is only ever raised on a valid channel, so any ready bit is a transfer.
    assign w_xfer     = |in_ready;
    assign w_gnt_data = in_data[int'(w_grant)*WIDTH +: WIDTH];

    // Output register and round-robin pointer; pointer only moves in mode 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= SELW'(NCH - 1);
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_gnt_data;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= w_grant;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MUXNTO1_TAG_EN
    logic [SELW-1:0] r_out_ch;

    // Source index travels with the data word and holds through stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_ch <= '0;
        end else if (w_xfer) begin
            r_out_ch <= w_grant;
        end
    end

    assign out_ch = r_out_ch;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_rr.sv
//============================================================================
// Module   : tb_mux_nto1_rr
// Purpose  : Self-checking bench for mux_nto1_rr (WIDTH=4, NCH=4 plus a
//            NCH=3 instance for the out-of-range select case). Hand tables,
//            short hand sequences and random stimulus against a reference model.
//            Honours MUXNTO1_TAG_EN when defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mux_nto1_rr;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic        out_valid3;
`ifdef MUXNTO1_TAG_EN
    logic [1:0]  out_ch;
    logic [1:0]  out_ch3;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit       m_valid;
    bit [3:0] m_data;
    int       m_ptr;
    int       m_ch;

    always #5 clk = ~clk;

    mux_nto1_rr #(.WIDTH(4), .NCH(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef MUXNTO1_TAG_EN
        .out_ch   (out_ch),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_nto1_rr #(.WIDTH(4), .NCH(3)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data[11:0]),
        .in_valid (in_valid[2:0]),
        .in_ready (in_ready3),
`ifdef MUXNTO1_TAG_EN
        .out_ch   (out_ch3),
`endif
        .out_data (out_data3),
        .out_valid(out_valid3),
        .out_ready(out_ready)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [15:0] data;
        logic        oready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [3:0]  exp_od;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_ptr   = NCH - 1;
        m_ch    = 0;
    endtask

    // Which channel the rules say gets the slot this cycle.
    function automatic void ref_grant(output bit gv, output int g);
        gv = 0;
        g  = 0;
        if (!mode) begin
            if (int'(sel) < NCH && in_valid[sel]) begin
                gv = 1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                int idx;
                idx = (m_ptr + k) % NCH;
                if (!gv && in_valid[idx]) begin
                    gv = 1;
                    g  = idx;
                end
            end
        end
    endfunction

    // Inputs are already driven at a negedge; check ready, clock, check outputs.
    task automatic tick(input bit use_tbl, input logic [3:0] t_ready,
                        input logic t_ov, input logic [3:0] t_od);
        bit       gv;
        int       g;
        bit       load;
        logic [3:0] exp_ready;
        #1;
        ref_grant(gv, g);
        load      = !m_valid || out_ready;
        exp_ready = (load && gv) ? 4'(1 << g) : 4'b0000;
        chk("in_ready_model", 32'(in_ready), 32'(exp_ready));
        if (use_tbl) chk("in_ready_table", 32'(in_ready), 32'(t_ready));
        @(posedge clk);
        if (load && gv) begin
            m_valid = 1;
            m_data  = 4'((in_data >> (g * 4)) & 16'hF);
            m_ch    = g;
            if (mode) m_ptr = g;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid_model", 32'(out_valid), 32'(m_valid));
        chk("out_data_model", 32'(out_data), 32'(m_data));
`ifdef MUXNTO1_TAG_EN
        chk("out_ch_model", 32'(out_ch), 32'(m_ch));
`endif
        if (use_tbl) begin
            chk("out_valid_table", 32'(out_valid), 32'(t_ov));
            chk("out_data_table", 32'(out_data), 32'(t_od));
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic [15:0] d, input logic r);
        mode      = m;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    vec_t tbl[15];

    initial begin
        // fixed select ch2 (ch2 = A), repeated
        tbl[0]  = '{1'b0, 2'd2, 4'hF, 16'h4A21, 1'b1, 4'b0100, 1'b1, 4'hA};
        tbl[1]  = '{1'b0, 2'd2, 4'hF, 16'h4A21, 1'b1, 4'b0100, 1'b1, 4'hA};
        // round-robin fairness, pointer still at 3 from reset
        tbl[2]  = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b1, 4'b0001, 1'b1, 4'h5};
        tbl[3]  = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b1, 4'b0010, 1'b1, 4'h6};
        tbl[4]  = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b1, 4'b0100, 1'b1, 4'h7};
        tbl[5]  = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b1, 4'b1000, 1'b1, 4'h8};
        tbl[6]  = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b1, 4'b0001, 1'b1, 4'h5};
        // move pointer to 3, then sparse ch1/ch3 wrap
        tbl[7]  = '{1'b1, 2'd0, 4'h8, 16'h8765, 1'b1, 4'b1000, 1'b1, 4'h8};
        tbl[8]  = '{1'b1, 2'd0, 4'hA, 16'h8765, 1'b1, 4'b0010, 1'b1, 4'h6};
        tbl[9]  = '{1'b1, 2'd0, 4'hA, 16'h8765, 1'b1, 4'b1000, 1'b1, 4'h8};
        tbl[10] = '{1'b1, 2'd0, 4'hA, 16'h8765, 1'b1, 4'b0010, 1'b1, 4'h6};
        // backpressure for 3 cycles, then drain and load together
        tbl[11] = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b0, 4'b0000, 1'b1, 4'h6};
        tbl[12] = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b0, 4'b0000, 1'b1, 4'h6};
        tbl[13] = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b0, 4'b0000, 1'b1, 4'h6};
        tbl[14] = '{1'b1, 2'd0, 4'hF, 16'h8765, 1'b1, 4'b0100, 1'b1, 4'h7};

        // Initial reset
        rst = 1'b1;
        drive(1'b1, 2'd0, 4'hF, 16'h8765, 1'b1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven scenarios
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].data, tbl[i].oready);
            tick(1'b1, tbl[i].exp_ready, tbl[i].exp_ov, tbl[i].exp_od);
        end

        // Out-of-range select on the 3-channel instance
        drive(1'b0, 2'd0, 4'h7, 16'h0A05, 1'b1);
        tick(1'b1, 4'b0001, 1'b1, 4'h5);
        chk("nch3_load_valid", 32'(out_valid3), 32'd1);
        chk("nch3_load_data", 32'(out_data3), 32'h5);
        drive(1'b0, 2'd3, 4'h7, 16'h0A05, 1'b1);
        #1;
        chk("nch3_sel3_ready", 32'(in_ready3), 32'd0);
        tick(1'b1, 4'b0000, 1'b0, 4'h5);
        chk("nch3_drain_valid", 32'(out_valid3), 32'd0);
        chk("nch3_hold_data", 32'(out_data3), 32'h5);
`ifdef MUXNTO1_TAG_EN
        chk("nch3_out_ch", 32'(out_ch3), 32'd0);
`endif

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick(1'b0, 4'b0, 1'b0, 4'b0);
        end

        // Asynchronous reset mid-cycle with a word pending
        drive(1'b1, 2'd0, 4'hF, 16'h8765, 1'b1);
        tick(1'b0, 4'b0, 1'b0, 4'b0);
        drive(1'b1, 2'd0, 4'hF, 16'h8765, 1'b0);
        #2;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_data", 32'(out_data), 32'd0);
        chk("async_reset_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 2'd0, 4'hF, 16'h8765, 1'b1);
        #1;
        chk("reset_held_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_held_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(1'b1, 4'b0001, 1'b1, 4'h5);
        tick(1'b1, 4'b0010, 1'b1, 4'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised, registered N:1 channel multiplexer. It is the next generation of the team's 4-bit 2:1 gate-level mux.
- Generalises data width and channel count.
- Adds valid/ready handshaking on every input and on the output, an output register stage, and two selection modes: fixed select and round-robin arbitration.
- Sits between multiple producer datapaths and a single shared consumer.

Parameters:
- WIDTH, 4, data width per channel in bits (>=1).
- NCH, 4, number of input channels (2..16).
- SELW, derived localparam = clog2(NCH), minimum 1; width of select and pointer fields.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready, combinational; at most one bit is set.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, rr_ptr=NCH-1, so channel 0 has first priority after reset.
- load_en = !out_valid || out_ready. The output register may load in the same cycle it is drained, giving full throughput of 1 word/cycle.
- Grant, combinational:
  - mode=0: grant=sel when sel<NCH and in_valid[sel]=1. Otherwise no grant; sel>=NCH never grants.
  - mode=1: grant is the first i with in_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NCH. No valid inputs means no grant.
- in_ready[i] = load_en && grant_valid && (grant==i). All in_ready bits are 0 when there is no grant.
- Transfer on input i: in_valid[i] && in_ready[i] at the clock edge.
  - Effect: out_data <= channel i data, out_valid <= 1.
  - In mode=1, rr_ptr <= i. rr_ptr is not updated in mode=0.
- Output drains when out_valid && out_ready. If no new transfer happens in that cycle, out_valid <= 0 and out_data holds its last value.
- Output stall (out_valid=1, out_ready=0): out_data and out_valid hold; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Mode or sel changes take effect in the next combinational grant evaluation. rr_ptr is retained across mode switches.
- Fairness (mode=1, all channels continuously valid, out_ready=1): grant order is 0,1,...,NCH-1,0,...
- Reset mid-transfer: a pending output word is discarded and no in_ready is asserted while rst=1.
- Producers must hold in_data/in_valid stable until their transfer completes. The block does not check this.

Optional Feature:
- Macro: MUXNTO1_TAG_EN.
- With the macro defined:
  - Adds output port out_ch [SELW-1:0], registered alongside out_data.
  - out_ch loads the granted channel index on each transfer; reset value 0; holds during stalls.
- Without the macro: out_ch does not exist and there is no index register.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0 and in_ready=0 immediately. After release with mode=1 and all valid -> channel 0 is granted first.
2. Fixed mode, WIDTH=4, NCH=4: mode=0, sel=2, in_data ch2=4'hA, all valid, out_ready=1 -> in_ready=4'b0100, and out_data=4'hA, out_valid=1 one cycle later. Repeating the same stimulus -> ch2 every cycle.
3. Round-robin fairness: mode=1, all four valid continuously, out_ready=1 -> out_data sequence follows ch0,ch1,ch2,ch3,ch0 at one word/cycle.
4. Sparse round-robin wrap: only ch1 and ch3 valid, rr_ptr=3 -> grant ch1, then ch3, then ch1.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0. When out_ready returns to 1 -> drain and load occur in the same cycle with no bubble.
6. Invalid select: mode=0, NCH=3, sel=3 -> no grant, in_ready=0, out_valid falls to 0 after draining. With MUXNTO1_TAG_EN defined, out_ch matches the source index in scenarios 2–4.
